// File: rtl/subckt_eval_sched.sv
// Round-robin scheduler sharing one flop-based evaluation subcircuit among NREQ requesters.
// Optional macro SCHED_SIG_EN adds an 8-bit LFSR signature (sig) of every returned result.
module subckt_eval_sched #(
  parameter int NREQ   = 4,
  parameter int DW     = 4,
  parameter int SETTLE = 3
) (
  input  logic               CLK,
  input  logic               RSTB,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_vec,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               result,
  output logic               busy,
  output logic               dut_rstb,
  output logic [DW-1:0]      dut_in,
  input  logic               dut_out
`ifdef SCHED_SIG_EN
  ,
  output logic [7:0]         sig
`endif
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, CLR, APPLY, CAPT, DONE} state_t;

  state_t          state, nstate;
  logic [PW-1:0]   rr_ptr, idx_q, pick_idx, nxt_ptr, j;
  logic            pick_vld, hold, abort;
  logic [3:0]      cnt;
  logic [DW-1:0]   vec_q;

  // first requester at or after rr_ptr; descending scan so the nearest one overwrites
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = PW'((int'(rr_ptr) + k) % NREQ);
      if (req[j]) begin
        pick_vld = 1'b1;
        pick_idx = j;
      end
    end
  end

  assign hold    = req[idx_q];
  assign abort   = (state == CLR || state == APPLY || state == CAPT) && !hold;
  assign nxt_ptr = (int'(idx_q) == NREQ-1) ? '0 : idx_q + 1'b1;

  assign busy     = (state != IDLE);
  assign done     = (state == DONE) ? gnt : '0;
  assign dut_in   = (state == CLR || state == APPLY) ? vec_q : '0;
  // subcircuit is held in reset with the scheduler and during CLR
  assign dut_rstb = RSTB & (state != CLR);

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (pick_vld) nstate = CLR;
      CLR:     nstate = APPLY;
      APPLY:   if (cnt == '0) nstate = CAPT;
      CAPT:    nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (abort) nstate = IDLE;
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      gnt    <= '0;
      idx_q  <= '0;
      vec_q  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      result <= 1'b0;
    end else if (abort) begin
      gnt    <= '0;
      rr_ptr <= nxt_ptr;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          gnt   <= NREQ'(1) << pick_idx;
          idx_q <= pick_idx;
          vec_q <= req_vec[pick_idx*DW +: DW];
        end
        CLR:   cnt <= 4'(SETTLE - 1);
        APPLY: if (cnt != '0) cnt <= cnt - 1'b1;
        CAPT:  result <= dut_out;
        DONE: begin
          gnt    <= '0;
          rr_ptr <= nxt_ptr;
        end
        default: ;
      endcase
    end
  end

`ifdef SCHED_SIG_EN
  // Galois LFSR x^8+x^6+x^5+x^4+1, folds in each completed result
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)              sig <= 8'h00;
    else if (state == DONE) sig <= {sig[6:0], sig[7] ^ result} ^ (sig[7] ? 8'h70 : 8'h00);
  end
`endif

endmodule

// File: tb/tb_subckt_eval_sched.sv
// Directed bench for subckt_eval_sched with a 3-stage flop subcircuit model and result scoreboard.
module tb_subckt_eval_sched;
  localparam int NREQ = 4, DW = 4, SETTLE = 3;

  logic               CLK = 1'b0;
  logic               RSTB;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_vec;
  logic [NREQ-1:0]    gnt, done;
  logic               result, busy, dut_rstb, dut_out;
  logic [DW-1:0]      dut_in;
`ifdef SCHED_SIG_EN
  logic [7:0]         sig;
  logic [7:0]         model_sig = 8'h00;
`endif

  typedef struct {int idx; logic res;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  subckt_eval_sched #(.NREQ(NREQ), .DW(DW), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RSTB(RSTB), .req(req), .req_vec(req_vec),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .dut_rstb(dut_rstb), .dut_in(dut_in), .dut_out(dut_out)
`ifdef SCHED_SIG_EN
    , .sig(sig)
`endif
  );

  // subcircuit model: output = dut_in[1] delayed through SETTLE flops
  logic s1, s2, s3;
  always @(posedge CLK or negedge dut_rstb) begin
    if (!dut_rstb) begin s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0; end
    else begin s1 <= dut_in[1]; s2 <= s1; s3 <= s2; end
  end
  assign dut_out = s3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic push(input int idx);
    exp_t e;
    e.idx = idx;
    e.res = req_vec[idx*DW + 1];
    sb.push_back(e);
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 50 && gnt == '0; i++) tick();
    chk("gnt_seen", 32'(gnt != '0), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && done == '0; i++) tick();
    chk("done_seen", 32'(done != '0), 32'd1);
  endtask

  // scoreboard: every done pulse must match the oldest expected completion
  always @(negedge CLK) begin
    if (RSTB && done !== '0) begin
      if (sb.size() == 0) chk("sb_unexpected_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_done", 32'(done), 32'(1 << e.idx));
        chk("sb_result", 32'(result), 32'(e.res));
`ifdef SCHED_SIG_EN
        chk("sb_sig", 32'(sig), 32'(model_sig));
        model_sig = {model_sig[6:0], model_sig[7] ^ e.res} ^ (model_sig[7] ? 8'h70 : 8'h00);
`endif
      end
    end
  end

  initial begin
    RSTB = 1'b0; req = '0; req_vec = '0;
    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dut_rstb", 32'(dut_rstb), 0);
    chk("rst_dut_in", 32'(dut_in), 0);
    chk("rst_result", 32'(result), 0);
    tick(); RSTB = 1'b1; tick();
    chk("idle_dut_rstb", 32'(dut_rstb), 1);

    // single request, requester 1, vector A
    req = 4'b0010; req_vec[7:4] = 4'hA; push(1);
    tick();
    chk("t1_gnt", 32'(gnt), 32'b0010);
    chk("t1_clr_rstb", 32'(dut_rstb), 0);
    chk("t1_clr_in", 32'(dut_in), 32'hA);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_apply_rstb", 32'(dut_rstb), 1);
    chk("t1_apply_in1", 32'(dut_in), 32'hA);
    tick(); tick();
    chk("t1_apply_in3", 32'(dut_in), 32'hA);
    tick();
    chk("t1_capt_in", 32'(dut_in), 0);
    chk("t1_capt_done", 32'(done), 0);
    tick();
    chk("t1_done", 32'(done), 32'b0010);
    chk("t1_result", 32'(result), 1);
    req = '0; tick();
    chk("t1_idle_gnt", 32'(gnt), 0);

    // restart pointer, then all four requesting
    RSTB = 1'b0;
`ifdef SCHED_SIG_EN
    model_sig = 8'h00;
`endif
    tick(); RSTB = 1'b1;
    req_vec = {4'h2, 4'h5, 4'hF, 4'h6};
    req = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    for (int t = 0; t < 5; t++) begin
      wait_gnt();
      chk("rr_gnt", 32'(gnt), 32'(1 << (t % NREQ)));
      wait_done();
      if (t == 4) req = '0;
      tick();
      chk("rr_gap_gnt", 32'(gnt), 0);
      chk("rr_gap_busy", 32'(busy), 0);
    end

    // abort: requester 2 drops in its 2nd APPLY cycle
    req_vec[11:8] = 4'h4; req = 4'b0100;
    tick();
    chk("ab_gnt", 32'(gnt), 32'b0100);
    tick(); tick();
    req = 4'b1010; push(3);
    tick();
    chk("ab_gnt0", 32'(gnt), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_result", 32'(result), 1);
    tick();
    chk("ab_next_gnt", 32'(gnt), 32'b1000);
    wait_done(); req = '0; tick();

    // req_vec change after grant is ignored
    req_vec[3:0] = 4'h5; req = 4'b0001; push(0);
    tick();
    chk("vc_clr_in", 32'(dut_in), 32'h5);
    tick(); req_vec[3:0] = 4'hF;
    chk("vc_apply_in1", 32'(dut_in), 32'h5);
    tick();
    chk("vc_apply_in2", 32'(dut_in), 32'h5);
    tick();
    chk("vc_apply_in3", 32'(dut_in), 32'h5);
    wait_done(); req = '0; tick();

    // asynchronous reset during APPLY
    req_vec[11:8] = 4'hA; req = 4'b0100;
    tick(); tick();
    chk("mr_busy_pre", 32'(busy), 1);
    #1 RSTB = 1'b0;
`ifdef SCHED_SIG_EN
    model_sig = 8'h00;
`endif
    #1;
    chk("mr_gnt", 32'(gnt), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_dut_in", 32'(dut_in), 0);
    chk("mr_dut_rstb", 32'(dut_rstb), 0);
    req_vec[3:0] = 4'h2; req = 4'b0101; push(0);
    tick(); RSTB = 1'b1;
    tick();
    chk("mr_first_gnt", 32'(gnt), 32'b0001);
    wait_done(); req = '0; tick(); tick();

    chk("sb_drained", 32'(sb.size()), 0);
`ifdef SCHED_SIG_EN
    chk("sig_final", 32'(sig), 32'(model_sig));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
